// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: func3 codes,
// exception codes, FSM states and the access legality checks.
package lsu_ctrl_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [1:0] EXC_TIMEOUT     = 2'b00;
  localparam logic [1:0] EXC_LD_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ST_MISALIGN = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  function automatic logic op_illegal(input logic rd, input logic wr, input logic [2:0] op);
    logic bad_ld;
    bad_ld = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
    op_illegal = (rd & wr) | (rd & bad_ld) | (wr & (op > LSU_W));
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      LSU_H, LSU_HU: op_misaligned = off[0];
      LSU_W:         op_misaligned = (off != 2'b00);
      default:       op_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / lane replication and
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_data,
  output logic [31:0] ld_ext
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  always_comb begin
    be       = '0;
    st_lanes = '0;
    case (st_size)
      LSU_B[1:0]: begin
        be       = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      LSU_H[1:0]: begin
        be       = st_off[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
      end
      default: begin
        be       = '1;
        st_lanes = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte   = '0;
    ld_half   = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
    ld_signed = ~ld_op[2];
    case (ld_off)
      2'd0:    ld_byte = ld_data[7:0];
      2'd1:    ld_byte = ld_data[15:8];
      2'd2:    ld_byte = ld_data[23:16];
      default: ld_byte = ld_data[31:24];
    endcase
    case (ld_op[1:0])
      2'b00:   ld_ext = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_ext = ld_data;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: one req/gnt(/rvalid) bus transaction per
// access, with legality checks in IDLE and a REQ+WAIT timeout abort.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  mem_op,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic        lsu_flush,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_exc,
  output logic [1:0]  lsu_exc_code,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  lsu_state_e  state;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [TO_W-1:0] to_cnt;
  logic        done_q;
  logic        to_exc_q;

  logic        acc;
  logic        illegal;
  logic        misaligned;
  logic        idle_exc;
  logic        launch;
  logic        expired;
  logic [3:0]  be_w;
  logic [31:0] lanes_w;
  logic [31:0] ld_ext;

  assign acc        = (mem_rd | mem_wr) & ~lsu_flush;
  assign illegal    = op_illegal(mem_rd, mem_wr, mem_op);
  assign misaligned = op_misaligned(mem_op, lsu_addr[1:0]);
  assign idle_exc   = (state == ST_IDLE) & acc & (illegal | misaligned);
  assign launch     = (state == ST_IDLE) & acc & ~illegal & ~misaligned;
  assign expired    = (to_cnt + TO_W'(1)) == TO_W'(TIMEOUT_CYC);

  assign lsu_stall  = (state == ST_REQ) | (state == ST_WAIT) | launch;
  assign lsu_done   = done_q;

  // IDLE exceptions are reported on the presenting cycle; the timeout abort
  // is registered and lines up with lsu_done. The two never overlap.
  assign lsu_exc      = to_exc_q | idle_exc;
  assign lsu_exc_code = !idle_exc ? EXC_TIMEOUT :
                        illegal   ? EXC_ILLEGAL :
                        mem_rd    ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;

  lsu_align u_align (
    .st_size  (mem_op[1:0]),
    .st_off   (lsu_addr[1:0]),
    .st_data  (lsu_wdata),
    .be       (be_w),
    .st_lanes (lanes_w),
    .ld_op    (op_q),
    .ld_off   (off_q),
    .ld_data  (dbus_rdata),
    .ld_ext   (ld_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      off_q      <= '0;
      to_cnt     <= '0;
      done_q     <= 1'b0;
      to_exc_q   <= 1'b0;
      lsu_rdata  <= '0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
    end else begin
      done_q   <= 1'b0;
      to_exc_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state      <= ST_REQ;
            dbus_req   <= 1'b1;
            dbus_we    <= mem_wr;
            dbus_addr  <= {lsu_addr[31:2], 2'b00};
            dbus_be    <= be_w;
            dbus_wdata <= mem_wr ? lanes_w : '0;
            op_q       <= mem_op;
            off_q      <= lsu_addr[1:0];
            to_cnt     <= '0;
          end
        end
        ST_REQ: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (dbus_gnt) begin
            dbus_req <= 1'b0;
            state    <= dbus_we ? ST_DONE : ST_WAIT;
            done_q   <= dbus_we;
          end else if (expired) begin
            dbus_req <= 1'b0;
            state    <= ST_DONE;
            done_q   <= 1'b1;
            to_exc_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (dbus_rvalid) begin
            lsu_rdata <= ld_ext;
            state     <= ST_DONE;
            done_q    <= 1'b1;
          end else if (expired) begin
            state    <= ST_DONE;
            done_q   <= 1'b1;
            to_exc_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl (TIMEOUT_CYC=4).
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr, lsu_flush;
  logic [2:0]  mem_op;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_stall, lsu_done, lsu_exc;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_exc_code;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYC(4), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_op(mem_op),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_flush(lsu_flush),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_exc(lsu_exc), .lsu_exc_code(lsu_exc_code), .dbus_req(dbus_req),
    .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Immediate-gnt/rvalid load; returns rdata and lsu_done seen in the DONE cycle.
  task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] bus,
                          output logic [31:0] got, output logic done_seen);
    mem_rd = 1'b1; mem_op = op; lsu_addr = addr;
    tick;
    mem_rd = 1'b0; dbus_gnt = 1'b1;
    tick;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = bus;
    tick;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    got = lsu_rdata;
    done_seen = lsu_done;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_rd = 0; mem_wr = 0; mem_op = '0; lsu_addr = '0; lsu_wdata = '0; lsu_flush = 0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = '0;
    repeat (2) tick;
    @(negedge clk);
    n_cmp++;
    if ({lsu_stall, lsu_done, lsu_exc, dbus_req, dbus_we} !== 5'b0 || lsu_rdata !== 32'h0 ||
        dbus_addr !== 32'h0 || dbus_be !== 4'h0 || dbus_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: stall=%b done=%b exc=%b req=%b we=%b rdata=%h addr=%h be=%b wdata=%h, all required 0",
               lsu_stall, lsu_done, lsu_exc, dbus_req, dbus_we, lsu_rdata, dbus_addr, dbus_be, dbus_wdata);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_load_word;
    mem_rd = 1'b1; mem_op = 3'b010; lsu_addr = 32'h100;
    @(negedge clk);
    n_cmp++;
    if (lsu_stall !== 1'b1 || dbus_req !== 1'b0) begin
      n_err++; $display("FAIL lw_c0: stall=%b req=%b required 1 0", lsu_stall, dbus_req);
    end
    tick;
    mem_rd = 1'b0; dbus_gnt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (lsu_stall !== 1'b1 || dbus_req !== 1'b1 || dbus_we !== 1'b0 || dbus_addr !== 32'h100 || dbus_be !== 4'hF) begin
      n_err++; $display("FAIL lw_c1: stall=%b req=%b we=%b addr=%h be=%b required 1 1 0 00000100 1111",
                        lsu_stall, dbus_req, dbus_we, dbus_addr, dbus_be);
    end
    tick;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if (lsu_stall !== 1'b1 || dbus_req !== 1'b0 || lsu_done !== 1'b0) begin
      n_err++; $display("FAIL lw_c2: stall=%b req=%b done=%b required 1 0 0", lsu_stall, dbus_req, lsu_done);
    end
    tick;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (lsu_done !== 1'b1 || lsu_stall !== 1'b0 || lsu_rdata !== 32'hDEADBEEF || lsu_exc !== 1'b0) begin
      n_err++; $display("FAIL lw_c3: done=%b stall=%b rdata=%h exc=%b required 1 0 deadbeef 0",
                        lsu_done, lsu_stall, lsu_rdata, lsu_exc);
    end
    tick;
    n_cmp++;
    if (lsu_done !== 1'b0) begin
      n_err++; $display("FAIL lw_done_pulse: done=%b required 0", lsu_done);
    end
    last_rd = 32'hDEADBEEF;
  endtask

  task automatic test_load_ext;
    logic [2:0]  ops  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] adrs [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
    logic [31:0] bus  [5] = '{32'h80123456, 32'h80123456, 32'h80011234, 32'h1234F00D, 32'h00007F00};
    logic [31:0] exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D, 32'h0000007F};
    logic [31:0] got;
    logic        dn;
    for (int i = 0; i < 5; i++) begin
      run_load(ops[i], adrs[i], bus[i], got, dn);
      n_cmp++;
      if (got !== exp[i] || dn !== 1'b1) begin
        n_err++; $display("FAIL load_ext[%0d]: rdata=%h done=%b required %h 1", i, got, dn, exp[i]);
      end
    end
    last_rd = 32'h0000007F;
  endtask

  task automatic test_store;
    logic [2:0]  ops  [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] adrs [3] = '{32'h202, 32'h201, 32'h300};
    logic [31:0] wd   [3] = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D};
    logic [31:0] ea   [3] = '{32'h200, 32'h200, 32'h300};
    logic [3:0]  eb   [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ew   [3] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      mem_wr = 1'b1; mem_op = ops[i]; lsu_addr = adrs[i]; lsu_wdata = wd[i];
      @(negedge clk);
      n_cmp++;
      if (lsu_stall !== 1'b1) begin
        n_err++; $display("FAIL store_c0[%0d]: stall=%b required 1", i, lsu_stall);
      end
      tick;
      mem_wr = 1'b0; dbus_gnt = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_addr !== ea[i] || dbus_be !== eb[i] || dbus_wdata !== ew[i]) begin
        n_err++; $display("FAIL store_bus[%0d]: req=%b we=%b addr=%h be=%b wdata=%h required 1 1 %h %b %h",
                          i, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, ea[i], eb[i], ew[i]);
      end
      tick;
      dbus_gnt = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (lsu_done !== 1'b1 || lsu_stall !== 1'b0 || dbus_req !== 1'b0 || lsu_exc !== 1'b0) begin
        n_err++; $display("FAIL store_done[%0d]: done=%b stall=%b req=%b exc=%b required 1 0 0 0",
                          i, lsu_done, lsu_stall, dbus_req, lsu_exc);
      end
      tick;
    end
  endtask

  task automatic test_exceptions;
    // rd, wr, op, addr, flush, expected exc, expected code
    logic        rd [7] = '{1, 1, 0, 1, 1, 0, 1};
    logic        wr [7] = '{0, 0, 1, 1, 0, 1, 0};
    logic [2:0]  op [7] = '{3'b010, 3'b011, 3'b010, 3'b000, 3'b111, 3'b100, 3'b010};
    logic [31:0] ad [7] = '{32'h101, 32'h100, 32'h102, 32'h100, 32'h101, 32'h100, 32'h100};
    logic        fl [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic        ee [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [1:0]  ec [7] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
    for (int i = 0; i < 7; i++) begin
      mem_rd = rd[i]; mem_wr = wr[i]; mem_op = op[i]; lsu_addr = ad[i]; lsu_flush = fl[i];
      @(negedge clk);
      n_cmp++;
      if (lsu_exc !== ee[i] || (ee[i] && lsu_exc_code !== ec[i]) || lsu_stall !== 1'b0) begin
        n_err++; $display("FAIL exc[%0d]: exc=%b code=%b stall=%b required %b %b 0",
                          i, lsu_exc, lsu_exc_code, lsu_stall, ee[i], ec[i]);
      end
      tick;
      mem_rd = 0; mem_wr = 0; lsu_flush = 0;
      @(negedge clk);
      n_cmp++;
      if (dbus_req !== 1'b0 || lsu_stall !== 1'b0 || lsu_exc !== 1'b0) begin
        n_err++; $display("FAIL exc_nolaunch[%0d]: req=%b stall=%b exc=%b required 0 0 0", i, dbus_req, lsu_stall, lsu_exc);
      end
      tick;
    end
  endtask

  task automatic test_timeout;
    mem_rd = 1'b1; mem_op = 3'b010; lsu_addr = 32'h400;
    tick;
    mem_rd = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dbus_req !== 1'b1 || lsu_stall !== 1'b1 || lsu_done !== 1'b0) begin
        n_err++; $display("FAIL timeout_req[c%0d]: req=%b stall=%b done=%b required 1 1 0", c, dbus_req, lsu_stall, lsu_done);
      end
      tick;
    end
    @(negedge clk);
    n_cmp++;
    if (lsu_done !== 1'b1 || lsu_exc !== 1'b1 || lsu_exc_code !== 2'b00 || dbus_req !== 1'b0 ||
        lsu_stall !== 1'b0 || lsu_rdata !== last_rd) begin
      n_err++; $display("FAIL timeout_abort: done=%b exc=%b code=%b req=%b stall=%b rdata=%h required 1 1 00 0 0 %h",
                        lsu_done, lsu_exc, lsu_exc_code, dbus_req, lsu_stall, lsu_rdata, last_rd);
    end
    tick;
    n_cmp++;
    if (lsu_done !== 1'b0 || lsu_exc !== 1'b0) begin
      n_err++; $display("FAIL timeout_pulse: done=%b exc=%b required 0 0", lsu_done, lsu_exc);
    end
  endtask

  task automatic test_gnt_on_expiry;
    mem_wr = 1'b1; mem_op = 3'b010; lsu_addr = 32'h500; lsu_wdata = 32'h01020304;
    tick;
    mem_wr = 1'b0;
    repeat (3) tick;
    dbus_gnt = 1'b1;
    tick;
    dbus_gnt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (lsu_done !== 1'b1 || lsu_exc !== 1'b0) begin
      n_err++; $display("FAIL gnt_on_expiry: done=%b exc=%b required 1 0", lsu_done, lsu_exc);
    end
    tick;
  endtask

  task automatic test_rvalid_in_req;
    mem_rd = 1'b1; mem_op = 3'b010; lsu_addr = 32'h600;
    tick;
    mem_rd = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hBAD0BAD0;
    tick;
    dbus_rvalid = 1'b0; dbus_gnt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dbus_req !== 1'b1 || lsu_done !== 1'b0) begin
      n_err++; $display("FAIL rvalid_in_req: req=%b done=%b required 1 0", dbus_req, lsu_done);
    end
    tick;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h600DF00D;
    tick;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (lsu_done !== 1'b1 || lsu_rdata !== 32'h600DF00D) begin
      n_err++; $display("FAIL rvalid_after_req: done=%b rdata=%h required 1 600df00d", lsu_done, lsu_rdata);
    end
    tick;
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] got;
    logic        dn;
    mem_rd = 1'b1; mem_op = 3'b010; lsu_addr = 32'h700;
    tick;
    mem_rd = 1'b0; dbus_gnt = 1'b1;
    tick;
    dbus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dbus_req !== 1'b0 || lsu_stall !== 1'b0) begin
      n_err++; $display("FAIL reset_in_wait: req=%b stall=%b required 0 0", dbus_req, lsu_stall);
    end
    tick;
    rst = 1'b0;
    tick;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h11111111;
    tick;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (lsu_done !== 1'b0 || lsu_rdata !== 32'h0 || lsu_stall !== 1'b0) begin
      n_err++; $display("FAIL stale_rvalid: done=%b rdata=%h stall=%b required 0 00000000 0", lsu_done, lsu_rdata, lsu_stall);
    end
    tick;
    run_load(3'b010, 32'h704, 32'h13579BDF, got, dn);
    n_cmp++;
    if (got !== 32'h13579BDF || dn !== 1'b1) begin
      n_err++; $display("FAIL load_after_reset: rdata=%h done=%b required 13579bdf 1", got, dn);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    logic        dn;
    run_load(3'b001, 32'h800, 32'h00008765, got, dn);
    n_cmp++;
    if (got !== 32'hFFFF8765 || dn !== 1'b1) begin
      n_err++; $display("FAIL b2b_first: rdata=%h done=%b required ffff8765 1", got, dn);
    end
    run_load(3'b101, 32'h802, 32'hC0DE0000, got, dn);
    n_cmp++;
    if (got !== 32'h0000C0DE || dn !== 1'b1) begin
      n_err++; $display("FAIL b2b_second: rdata=%h done=%b required 0000c0de 1", got, dn);
    end
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_load_ext;
    test_store;
    test_exceptions;
    test_timeout;
    test_gnt_on_expiry;
    test_rvalid_in_req;
    test_reset_in_wait;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
